presentation_timer: RTL

- Downstream consumer of the programmable clock divider output.
- Samples the divided square wave in the `clk` domain and turns each rising edge into a one-cycle tick.
- Uses the ticks to run a minutes:seconds presentation countdown with start/pause/clear control, a low-time warning and an expiry flag.
- Drives the display/LED logic of the presentation controller.

---
 rtl/presentation_timer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/presentation_timer.sv
// presentation_timer: minutes:seconds countdown driven by the rising edges of
// a divided clock (tick_src). Provides start/pause/clear control, a low-time
// warning and an expiry flag for the presentation controller display.
// Optional build macro: PRESENTATION_TIMER_OVERTIME_EN -- when defined, the
// EXPIRED state counts overtime upward (saturating at MAX_MIN:59) instead of
// freezing at 00:00.
module presentation_timer #(
    parameter int MAX_MIN  = 99,
    parameter int WARN_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_src,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [6:0] load_min,
    output logic [6:0] min_out,
    output logic [5:0] sec_out,
    output logic       tick_out,
    output logic       running,
    output logic       warn,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [6:0]  MAX_MIN_C  = 7'(MAX_MIN);
    localparam logic [12:0] WARN_SEC_C = 13'(WARN_SEC);

    state_e     state_q, state_d;
    logic [6:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       src_q;
    logic       tick_out_q;
    logic       running_q;
    logic       warn_q, warn_d;
    logic       expired_q;
    logic       tick_s;
    logic [6:0] preset_s;
    logic [12:0] total_d_s;

    // Total remaining seconds of a min:sec pair (fits 13 bits for min <= 127).
    function automatic logic [12:0] total_seconds(input logic [6:0] m, input logic [5:0] s);
        return ({6'd0, m} * 13'd60) + {7'd0, s};
    endfunction

    // Rising edge of the divided clock, used by the counter on the same edge.
    assign tick_s   = tick_src & ~src_q;

    // Preset minutes clamped to the largest accepted value.
    assign preset_s = (load_min > MAX_MIN_C) ? MAX_MIN_C : load_min;

    assign total_d_s = total_seconds(min_d, sec_d);

    // Next-state and next-time computation with clear > start > pause priority.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        case (state_q)
            ST_IDLE: begin
                // IDLE continuously tracks the preset; a start uses the value loaded on that edge.
                min_d = preset_s;
                sec_d = 6'd0;
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (preset_s == 7'd0) begin
                        state_d = ST_EXPIRED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (pause && !start) begin
                    // A tick coinciding with pause is dropped.
                    state_d = ST_PAUSED;
                end else if (tick_s) begin
                    // start in RUN has no effect, so the tick is applied normally.
                    if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                    end else if (min_q != 7'd0) begin
                        min_d = min_q - 7'd1;
                        sec_d = 6'd59;
                    end else begin
                        min_d = min_q;
                        sec_d = sec_q;
                    end
                    if ((min_d == 7'd0) && (sec_d == 6'd0)) begin
                        state_d = ST_EXPIRED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    // Resume; any tick in this cycle is ignored.
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_EXPIRED: begin
                if (clear) begin
                    state_d = ST_IDLE;
`ifdef PRESENTATION_TIMER_OVERTIME_EN
                end else if (tick_s) begin
                    // Overtime counts upward, saturating at MAX_MIN:59.
                    state_d = ST_EXPIRED;
                    if (sec_q != 6'd59) begin
                        sec_d = sec_q + 6'd1;
                    end else if (min_q < MAX_MIN_C) begin
                        min_d = min_q + 7'd1;
                        sec_d = 6'd0;
                    end else begin
                        min_d = min_q;
                        sec_d = sec_q;
                    end
`endif
                end else begin
                    state_d = ST_EXPIRED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                min_d   = 7'd0;
                sec_d   = 6'd0;
            end
        endcase
    end

    // Warning is derived from the next state/time so it lines up with the registered time.
    always_comb begin
        warn_d = 1'b0;
        if (((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
            (total_d_s != 13'd0) && (total_d_s <= WARN_SEC_C)) begin
            warn_d = 1'b1;
        end else begin
            warn_d = 1'b0;
        end
    end

    // State, time, edge detect and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            min_q      <= 7'd0;
            sec_q      <= 6'd0;
            src_q      <= 1'b0;
            tick_out_q <= 1'b0;
            running_q  <= 1'b0;
            warn_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            src_q      <= tick_src;
            tick_out_q <= tick_s;
            running_q  <= (state_d == ST_RUN);
            warn_q     <= warn_d;
            expired_q  <= (state_d == ST_EXPIRED);
        end
    end

    assign min_out  = min_q;
    assign sec_out  = sec_q;
    assign tick_out = tick_out_q;
    assign running  = running_q;
    assign warn     = warn_q;
    assign expired  = expired_q;

endmodule
